// File: rtl/eco32_ethernet_ptr_ctrl_pkg.sv
// Shared types for the Ethernet pointer-buffer client controller.
// Pointer words are 36 bits; the RAM returns read data 2 cycles late.
package eco32_ethernet_pkg;
   localparam int PTR_WORD_W = 36;
   localparam int RAM_RD_LAT = 2;
   typedef logic [PTR_WORD_W-1:0] ptr_word_t;
endpackage

// File: rtl/eco32_ethernet_ptr_ctrl_if.sv
// Push, pop and RAM-port signals of one pointer-buffer half.
// The slave modport is the controller side.
interface eco32_ethernet_ptr_ctrl_if #(
   parameter int AW = 7
);
   import eco32_ethernet_pkg::*;

   logic      push_i_stb;
   ptr_word_t push_i_data;
   logic      push_o_rdy;
   logic      pop_o_stb;
   ptr_word_t pop_o_data;
   logic      pop_i_ack;
   logic      mem_o_stb;
   logic      mem_o_wen;
   ptr_word_t mem_o_data;
   logic [AW-1:0] mem_o_addr;
   logic      mem_i_stb;
   ptr_word_t mem_i_data;

   modport slave (
      input  push_i_stb, push_i_data, pop_i_ack,
      input  mem_i_stb, mem_i_data,
      output push_o_rdy, pop_o_stb, pop_o_data,
      output mem_o_stb, mem_o_wen, mem_o_data, mem_o_addr
   );

   modport master (
      output push_i_stb, push_i_data, pop_i_ack,
      output mem_i_stb, mem_i_data,
      input  push_o_rdy, pop_o_stb, pop_o_data,
      input  mem_o_stb, mem_o_wen, mem_o_data, mem_o_addr
   );
endinterface

// File: rtl/eco32_ethernet_ptr_ofifo.sv
// First-word-fall-through prefetch FIFO holding RAM read responses.
// Reads must only be requested while not empty.
module eco32_ethernet_ptr_ofifo
   import eco32_ethernet_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr,
   input  ptr_word_t                wr_data,
   input  logic                     rd,
   output ptr_word_t                rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occ
);
   localparam int PW = $clog2(DEPTH);

   ptr_word_t     mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         occ <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         occ <= occ + {{PW{1'b0}}, wr} - {{PW{1'b0}}, rd};
      end
   end

   assign rd_data = mem[rp];
   assign empty   = (occ == '0);
endmodule

// File: rtl/eco32_ethernet_ptr_ctrl.sv
// Circular-FIFO client for one half of the pointer buffer RAM.
// Optional ETH_PTR_CTRL_LEVEL_EN adds a registered fill level output.
module eco32_ethernet_ptr_ctrl
   import eco32_ethernet_pkg::*;
#(
   parameter int BUFF_ADDR_WIDTH = 8,
   parameter int OFIFO_DEPTH     = 4
) (
   input  logic clk,
   input  logic rst,
   eco32_ethernet_ptr_ctrl_if.slave bus
`ifdef ETH_PTR_CTRL_LEVEL_EN
   ,
   output logic [BUFF_ADDR_WIDTH:0] level_o
`endif
);
   localparam int AW    = BUFF_ADDR_WIDTH - 1;
   localparam int DEPTH = 1 << AW;
   localparam int OW    = $clog2(OFIFO_DEPTH);
   localparam logic [BUFF_ADDR_WIDTH-1:0] FULL =
      BUFF_ADDR_WIDTH'(DEPTH);
   localparam logic [OW+1:0] CAP = (OW+2)'(OFIFO_DEPTH);

   logic [AW-1:0]              wr_ptr;
   logic [AW-1:0]              rd_ptr;
   logic [BUFF_ADDR_WIDTH-1:0] mem_cnt;
   logic [1:0]                 inflight;
   logic [OW:0]                occ;
   logic [OW+1:0]              credit;
   logic                       empty;
   logic                       rd_req;
   logic                       wr_en;
   logic                       resp;
   logic                       pop;

   // Reads own the port whenever there is room for the response.
   assign credit = {1'b0, occ} + {{OW{1'b0}}, inflight};
   assign rd_req = !rst && (mem_cnt != '0) && (credit < CAP);
   assign bus.push_o_rdy = !rst && !rd_req && (mem_cnt != FULL);
   assign wr_en  = bus.push_o_rdy && bus.push_i_stb;
   // Stale responses after a reset find inflight at zero.
   assign resp   = bus.mem_i_stb && (inflight != 2'd0);
   assign pop    = bus.pop_o_stb && bus.pop_i_ack;

   always_comb begin
      bus.mem_o_stb  = 1'b0;
      bus.mem_o_wen  = 1'b0;
      bus.mem_o_data = '0;
      bus.mem_o_addr = '0;
      if (rd_req) begin
         bus.mem_o_stb  = 1'b1;
         bus.mem_o_addr = rd_ptr;
      end else if (wr_en) begin
         bus.mem_o_stb  = 1'b1;
         bus.mem_o_wen  = 1'b1;
         bus.mem_o_addr = wr_ptr;
         bus.mem_o_data = bus.push_i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr  <= wr_ptr + 1'b1;
            mem_cnt <= mem_cnt + 1'b1;
         end else if (rd_req) begin
            rd_ptr  <= rd_ptr + 1'b1;
            mem_cnt <= mem_cnt - 1'b1;
         end
         case ({rd_req, resp})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   eco32_ethernet_ptr_ofifo #(
      .DEPTH(OFIFO_DEPTH)
   ) u_ofifo (
      .clk    (clk),
      .rst    (rst),
      .wr     (resp),
      .wr_data(bus.mem_i_data),
      .rd     (pop),
      .rd_data(bus.pop_o_data),
      .empty  (empty),
      .occ    (occ)
   );

   assign bus.pop_o_stb = !empty;

`ifdef ETH_PTR_CTRL_LEVEL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         level_o <= '0;
      end else begin
         level_o <= (BUFF_ADDR_WIDTH+1)'(mem_cnt)
                  + (BUFF_ADDR_WIDTH+1)'(inflight)
                  + (BUFF_ADDR_WIDTH+1)'(occ);
      end
   end
`endif
endmodule

// File: tb/tb_eco32_ethernet_ptr_ctrl.sv
// Randomised bench for eco32_ethernet_ptr_ctrl with a 2-cycle RAM model
// and an in-order word queue as reference.
module tb_eco32_ethernet_ptr_ctrl;
   import eco32_ethernet_pkg::*;

   localparam int BAW = 4;
   localparam int AW  = BAW - 1;
   localparam int RD  = 8;
   localparam int CAP = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   eco32_ethernet_ptr_ctrl_if #(.AW(AW)) bus ();

`ifdef ETH_PTR_CTRL_LEVEL_EN
   logic [BAW:0] level;
`endif

   eco32_ethernet_ptr_ctrl #(
      .BUFF_ADDR_WIDTH(BAW),
      .OFIFO_DEPTH    (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef ETH_PTR_CTRL_LEVEL_EN
      ,
      .level_o(level)
`endif
   );

   // RAM model: write on the strobe edge, read data 2 cycles later
   ptr_word_t ram [RD];
   logic      s1v = 1'b0;
   logic      s2v = 1'b0;
   ptr_word_t s1d = '0;
   ptr_word_t s2d = '0;

   initial for (int i = 0; i < RD; i++) ram[i] = '0;

   always @(posedge clk) begin
      if (bus.mem_o_stb && bus.mem_o_wen) ram[bus.mem_o_addr] <= bus.mem_o_data;
      s1v <= bus.mem_o_stb && !bus.mem_o_wen;
      s1d <= ram[bus.mem_o_addr];
      s2v <= s1v;
      s2d <= s1d;
   end

   assign bus.mem_i_stb  = s2v;
   assign bus.mem_i_data = s2d;

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: every accepted word must come out in order; RAM
   // addresses follow the count of writes/reads modulo the half depth.
   ptr_word_t q[$];
   int wcnt = 0;
   int rcnt = 0;
   int pushes = 0;
   int pops = 0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_rdy", bus.push_o_rdy, 0);
         check("rst_mem_stb", bus.mem_o_stb, 0);
         q.delete();
         wcnt = 0;
         rcnt = 0;
      end else begin
         if (bus.mem_o_stb && bus.mem_o_wen) begin
            check("wr_addr", bus.mem_o_addr, wcnt % RD);
            check("wr_data", bus.mem_o_data, bus.push_i_data);
            check("wr_is_push", bus.push_i_stb && bus.push_o_rdy, 1);
            wcnt++;
         end
         if (bus.mem_o_stb && !bus.mem_o_wen) begin
            check("rd_addr", bus.mem_o_addr, rcnt % RD);
            rcnt++;
            check("rd_not_empty", rcnt <= wcnt, 1);
         end
         check("ram_bound", (wcnt - rcnt) <= RD, 1);
         if (q.size() >= CAP) check("full_rdy", bus.push_o_rdy, 0);
         if (bus.push_i_stb && bus.push_o_rdy)
            check("push_to_ram", bus.mem_o_stb && bus.mem_o_wen, 1);
         if (bus.pop_o_stb) begin
            check("pop_has_word", q.size() > 0, 1);
            if (bus.pop_i_ack && q.size() > 0) begin
               check("pop_data", bus.pop_o_data, q[0]);
               void'(q.pop_front());
               pops++;
            end
         end
         if (bus.push_i_stb && bus.push_o_rdy) begin
            q.push_back(bus.push_i_data);
            pushes++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic ptr_word_t rnd_word();
      return {4'($urandom_range(15)), 32'($urandom)};
   endfunction

   task automatic push_word(input ptr_word_t d, output bit ok);
      ok = 1'b0;
      bus.push_i_stb  = 1'b1;
      bus.push_i_data = d;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.push_o_rdy) ok = 1'b1;
         step();
      end
      bus.push_i_stb = 1'b0;
   endtask

   task automatic wait_pop(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.pop_o_stb && bus.pop_i_ack) ok = 1'b1;
         step();
      end
   endtask

   initial begin
      bit ok;
      int p0;
      int n;
      int gaps;
      bit started;

      rst = 1'b1;
      bus.push_i_stb  = 1'b0;
      bus.push_i_data = '0;
      bus.pop_i_ack   = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      @(negedge clk);
      check("reset_pop_stb", bus.pop_o_stb, 0);
      check("reset_rdy", bus.push_o_rdy, 1);
      check("reset_mem_stb", bus.mem_o_stb, 0);

      // single word latency
      step();
      bus.pop_i_ack   = 1'b1;
      bus.push_i_stb  = 1'b1;
      bus.push_i_data = 36'h0DEADBEEF;
      @(negedge clk);
      check("t0_wr_stb", {bus.mem_o_stb, bus.mem_o_wen}, 2'b11);
      check("t0_wr_addr", bus.mem_o_addr, 0);
      check("t0_wr_data", bus.mem_o_data, 36'h0DEADBEEF);
      step();
      bus.push_i_stb = 1'b0;
      @(negedge clk);
      check("t1_rd_stb", {bus.mem_o_stb, bus.mem_o_wen}, 2'b10);
      check("t1_rd_addr", bus.mem_o_addr, 0);
      step();
      @(negedge clk);
      check("t2_pop_stb", bus.pop_o_stb, 0);
      step();
      @(negedge clk);
      check("t3_pop_stb", bus.pop_o_stb, 0);
      step();
      @(negedge clk);
      check("t4_pop_stb", bus.pop_o_stb, 1);
      check("t4_pop_data", bus.pop_o_data, 36'h0DEADBEEF);
      step();
      @(negedge clk);
      check("t5_pop_stb", bus.pop_o_stb, 0);

      // fill with no consumer
      step();
      bus.pop_i_ack  = 1'b0;
      p0 = pushes;
      bus.push_i_stb = 1'b1;
      for (int i = 0; i < 40; i++) begin
         bus.push_i_data = rnd_word();
         step();
      end
      bus.push_i_stb = 1'b0;
      check("fill_count", pushes - p0, CAP);
      @(negedge clk);
      check("fill_rdy", bus.push_o_rdy, 0);
      check("fill_pop_stb", bus.pop_o_stb, 1);

      // drain
      step();
      bus.pop_i_ack = 1'b1;
      n = 0;
      gaps = 0;
      started = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.pop_o_stb) begin
            started = 1'b1;
            n++;
         end else if (started && n < CAP) begin
            gaps++;
         end
         step();
      end
      check("drain_count", n, CAP);
      check("drain_gaps", gaps, 0);
      @(negedge clk);
      check("drain_pop_stb", bus.pop_o_stb, 0);
      check("drain_rdy", bus.push_o_rdy, 1);

      // reset with two reads in flight
      step();
      bus.pop_i_ack  = 1'b0;
      bus.push_i_stb = 1'b1;
      for (int i = 0; i < 30; i++) begin
         bus.push_i_data = rnd_word();
         step();
      end
      bus.push_i_stb = 1'b0;
      bus.pop_i_ack  = 1'b1;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.mem_o_stb && !bus.mem_o_wen) n++;
         step();
      end
      check("rst_reads_inflight", n, 2);
      rst = 1'b1;
      bus.pop_i_ack = 1'b0;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) check("stale_resp_seen", bus.mem_i_stb, 1);
         check("post_rst_pop_stb", bus.pop_o_stb, 0);
         check("post_rst_rdy", bus.push_o_rdy, 1);
         step();
      end

      // wrap: push/pop pairs
      bus.pop_i_ack = 1'b1;
      p0 = pops;
      for (int k = 0; k < 20; k++) begin
         push_word(rnd_word(), ok);
         check("wrap_push_ok", ok, 1);
         wait_pop(ok);
         check("wrap_pop_ok", ok, 1);
      end
      check("wrap_pops", pops - p0, 20);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         bus.push_i_stb  = 1'($urandom_range(1));
         bus.push_i_data = rnd_word();
         bus.pop_i_ack   = ($urandom_range(3) != 0);
         if (i % 150 > 110) bus.pop_i_ack = 1'b0;
         step();
      end
      bus.push_i_stb = 1'b0;
      bus.pop_i_ack  = 1'b1;
      repeat (40) step();
      @(negedge clk);
      check("final_pop_stb", bus.pop_o_stb, 0);
      check("final_all_popped", q.size(), 0);

`ifdef ETH_PTR_CTRL_LEVEL_EN
      step();
      bus.pop_i_ack = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push_word(rnd_word(), ok);
         check("lvl_push_ok", ok, 1);
      end
      repeat (8) step();
      bus.pop_i_ack = 1'b1;
      wait_pop(ok);
      check("lvl_pop_ok", ok, 1);
      wait_pop(ok);
      check("lvl_pop_ok", ok, 1);
      bus.pop_i_ack = 1'b0;
      repeat (6) step();
      @(negedge clk);
      check("level_3", level, 3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/eco32_ethernet_ptr_ctrl.md
Name: eco32_ethernet_ptr_ctrl

Overview:
Client-side controller that drives one half-port (A or B) of the Ethernet pointer buffer RAM and runs that half as a circular FIFO of 36-bit pointer words. It accepts pushes from a producer and converts them into RAM writes. It issues RAM reads, absorbs the fixed 2-cycle read latency and presents the words to a consumer through a stb/ack pop interface. One instance sits next to each pointer-buffer port, e.g. the RX-free-list side and the TX-done side.

Parameters:
BUFF_ADDR_WIDTH, 8, pointer RAM address width; this block owns one half, so DEPTH = 2^(BUFF_ADDR_WIDTH-1) words.
OFIFO_DEPTH, 4, output prefetch FIFO entries; must be a power of two and at least 4, to cover the 2-cycle latency plus one pop.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
push_i_stb  in  1  producer offers a word.
push_i_data  in  36  pointer word.
push_o_rdy  out  1  word accepted this cycle when push_i_stb && push_o_rdy.
pop_o_stb  out  1  head word valid.
pop_o_data  out  36  head word.
pop_i_ack  in  1  consumer takes the head word when pop_o_stb && pop_i_ack.
mem_o_stb  out  1  RAM access strobe.
mem_o_wen  out  1  1 = write, 0 = read.
mem_o_data  out  36  write data.
mem_o_addr  out  BUFF_ADDR_WIDTH-1  half-local address.
mem_i_stb  in  1  read data valid, 2 cycles after a read strobe.
mem_i_data  in  36  read data.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- State:
  - wr_ptr and rd_ptr: BUFF_ADDR_WIDTH-1 bits each; wrap naturally modulo DEPTH.
  - mem_cnt: BUFF_ADDR_WIDTH bits, range 0..DEPTH.
  - inflight: 2 bits.
  - ofifo occupancy.
- Reset values: all pointers and counters 0; ofifo empty; push_o_rdy=0 during reset; pop_o_stb=0; all mem_o_* = 0.
- RAM port is shared, one access per cycle:
  - rd_req = (mem_cnt != 0) && (ofifo_occ + inflight < OFIFO_DEPTH).
  - Reads take priority over writes.
  - push_o_rdy = !rst && !rd_req && (mem_cnt != DEPTH). It does not depend on push_i_stb.
- Outputs are combinational from registered state:
  - Read cycle: mem_o_stb=1, mem_o_wen=0, mem_o_addr=rd_ptr.
  - Write cycle (accepted push): mem_o_stb=1, mem_o_wen=1, mem_o_addr=wr_ptr, mem_o_data=push_i_data.
  - Otherwise: mem_o_stb=0.
- Counter updates:
  - Write: wr_ptr+1, mem_cnt+1.
  - Read issue: rd_ptr+1, mem_cnt-1, inflight+1.
  - Read and write never happen in the same cycle, so mem_cnt never increments and decrements at once.
- Read response: mem_i_stb writes mem_i_data into the ofifo and decrements inflight.
  - A response and a new read issue in the same cycle leave inflight unchanged.
  - The credit rule guarantees the ofifo never overflows. mem_i_stb arriving with the ofifo full is a protocol error; behaviour is undefined.
- Pop side:
  - pop_o_stb = ofifo not empty; pop_o_data = ofifo head (first-word-fall-through).
  - A response and a pop in the same cycle are both honoured.
- Latency:
  - Pushed word in an empty system → visible on pop_o_stb 4 cycles after the push edge: write, read issue, 2-cycle RAM, ofifo.
  - Total capacity is DEPTH + OFIFO_DEPTH.
- Boundary conditions:
  - Full (mem_cnt==DEPTH): push_o_rdy=0.
  - Empty: no reads issued; pop_o_stb falls after the last word is popped.
- Reset mid-operation: counters cleared; any in-flight responses arriving after reset are ignored, because inflight=0 masks mem_i_stb. RAM contents are not cleared.

Optional Feature:
ETH_PTR_CTRL_LEVEL_EN
- Defined: adds output level_o [BUFF_ADDR_WIDTH:0], registered, equal to mem_cnt + inflight + ofifo_occ. Reset value 0. Updated one cycle after each event.
- Undefined: port and logic are absent.

Decomposition:
- Package eco32_ethernet_pkg:
  - PTR_WORD_W = 36.
  - RAM_RD_LAT = 2.
  - Typedef ptr_word_t.
- Sub-module eco32_ethernet_ptr_ofifo: OFIFO_DEPTH-entry first-word-fall-through FIFO with wr/rd/empty/occ.

Test Plan (BUFF_ADDR_WIDTH=4, DEPTH=8; bench RAM model with 2-cycle latency):
- Single push of 0x0_DEAD_BEEF at cycle 10, pop_i_ack=1 → mem write to addr 0 at cycle 10, read of addr 0 at cycle 11, pop_o_stb=1 with 0x0_DEAD_BEEF at cycle 14.
- Continuous pushes with pop_i_ack=0 → 12 words accepted (8 in RAM + 4 in ofifo), then push_o_rdy=0; mem_o_addr for writes runs 0..7 and then 0..3.
- Drain after the fill above with pop_i_ack=1 → 12 words popped in push order with no gaps once streaming; pop_o_stb=0 afterwards.
- Wrap test: 20 push/pop pairs → wr_ptr and rd_ptr wrap 7→0 and data order is preserved.
- rst asserted with 2 reads in flight → mem_i_stb in the next 2 cycles is ignored; pop_o_stb=0 and push_o_rdy=1 after reset.
- With ETH_PTR_CTRL_LEVEL_EN: 5 pushes, 2 pops → level_o=3.
